// File: rtl/sseg_mux8.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_mux8
//  Description : Eight-digit common-anode 7-segment display multiplexer.
//                Latches the 8-nibble window once per frame into shadow
//                registers, then scans digits 0..7 with a dark lead-in at
//                the start of every slot (anti-ghosting) and a 16-level
//                PWM brightness window. Hex decode, decimal points and
//                per-digit blanking are applied per digit.
//  Ports       :
//     CLK100MHZ   in   1   system clock
//     CPU_RESETN  in   1   asynchronous active-low reset
//     DATA        in   32  digit i = DATA[4i+3:4i]; digit 0 is AN[0]
//     DP          in   8   1 = decimal point of digit i lit
//     EN          in   8   1 = digit i shown, 0 = digit i blank
//     BRIGHT      in   4   duty level, 0 = 1/16 on .. 15 = full on (live)
//     AN          out  8   anode enables, active-low
//     SSEG        out  8   segments, active-low, [0]=a .. [6]=g, [7]=dp
//     FRAME_TICK  out  1   one-cycle pulse after each shadow load
//  Revision    : 1.0  initial release
// ============================================================================
module sseg_mux8 #(
   parameter int DIGIT_TICKS = 100_000,  // clocks per digit slot, > BLANK_TICKS
   parameter int BLANK_TICKS = 1_000     // dark clocks at slot start, >= 1
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic [31:0] DATA,
   input  logic [7:0]  DP,
   input  logic [7:0]  EN,
   input  logic [3:0]  BRIGHT,
   output logic [7:0]  AN,
   output logic [7:0]  SSEG,
   output logic        FRAME_TICK
);

   localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

   localparam logic [CW-1:0] c_slot_last  = CW'(DIGIT_TICKS - 1);
   localparam logic [CW-1:0] c_blank_last = CW'(BLANK_TICKS - 1);
   localparam logic [CW-1:0] c_blank_end  = CW'(BLANK_TICKS);

   logic [CW-1:0] r_slot_cnt;
   logic [2:0]    r_digit;
   logic [3:0]    r_pwm_cnt;
   logic [31:0]   r_sh_data;
   logic [7:0]    r_sh_dp;
   logic [7:0]    r_sh_en;
   logic          r_load_pending;
   logic          r_frame_tick;
   logic [7:0]    r_an;
   logic [7:0]    r_sseg;

   logic          w_slot_wrap;
   logic          w_frame_end;
   logic          w_load;
   logic [3:0]    w_nib;
   logic          w_lit;
   logic [6:0]    w_seg;

   assign w_slot_wrap = (r_slot_cnt == c_slot_last);
   assign w_frame_end = w_slot_wrap && (r_digit == 3'd7);
   // The first edge after reset loads unconditionally so the display never
   // waits a whole frame for valid content.
   assign w_load      = r_load_pending || w_frame_end;
   assign w_nib       = r_sh_data[{r_digit, 2'b00} +: 4];

   // PWM counter restarts on the last dark cycle, so the lit window begins
   // with pwm_cnt == 0 on the first active cycle of every slot.
   assign w_lit = (r_slot_cnt >= c_blank_end) && r_sh_en[r_digit] &&
                  (r_pwm_cnt <= BRIGHT);

   // Hex font, bit order g..a, active-low.
   always_comb begin
      w_seg = 7'h7F;
      case (w_nib)
         4'h0: w_seg = 7'h40;
         4'h1: w_seg = 7'h79;
         4'h2: w_seg = 7'h24;
         4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;
         4'h5: w_seg = 7'h12;
         4'h6: w_seg = 7'h02;
         4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;
         4'h9: w_seg = 7'h10;
         4'hA: w_seg = 7'h08;
         4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;
         4'hD: w_seg = 7'h21;
         4'hE: w_seg = 7'h06;
         4'hF: w_seg = 7'h0E;
         default: w_seg = 7'h7F;
      endcase
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_slot_cnt     <= '0;
         r_digit        <= 3'd0;
         r_pwm_cnt      <= 4'd0;
         r_sh_data      <= 32'd0;
         r_sh_dp        <= 8'd0;
         r_sh_en        <= 8'd0;
         r_load_pending <= 1'b1;
         r_frame_tick   <= 1'b0;
         r_an           <= 8'hFF;
         r_sseg         <= 8'hFF;
      end else begin
         if (w_load) begin
            r_sh_data      <= DATA;
            r_sh_dp        <= DP;
            r_sh_en        <= EN;
            r_load_pending <= 1'b0;
         end
         r_frame_tick <= w_load;

         if (w_slot_wrap) begin
            r_slot_cnt <= '0;
            r_digit    <= r_digit + 3'd1;   // 7 wraps to 0
         end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
         end

         if (r_slot_cnt == c_blank_last) begin
            r_pwm_cnt <= 4'd0;
         end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
         end

         // Outputs reflect the counter/shadow state of this cycle.
         if (w_lit) begin
            r_an   <= ~(8'b1 << r_digit);
            r_sseg <= {~r_sh_dp[r_digit], w_seg};
         end else begin
            r_an   <= 8'hFF;
            r_sseg <= 8'hFF;
         end
      end
   end

   assign AN         = r_an;
   assign SSEG       = r_sseg;
   assign FRAME_TICK = r_frame_tick;

endmodule
`default_nettype wire
